// File: rtl/cpu16_pkg.sv
// Shared cpu16 control-path encodings: FSM states, opcodes, ALU codes and the
// per-state datapath control word used by the main FSM and the ALU control stage.
package cpu16_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_FAULT    = 4'd11
  } state_t;

  localparam logic [3:0] OP_R0  = 4'b0000;
  localparam logic [3:0] OP_R1  = 4'b0001;
  localparam logic [3:0] OP_I0  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b0110;
  localparam logic [3:0] OP_I1  = 4'b1001;
  localparam logic [3:0] OP_I2  = 4'b1010;
  localparam logic [3:0] OP_I3  = 4'b1011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_source;
    logic       fault;
  } ctrl_t;

  // Moore control word for each state; anything not named stays 0.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_ONE;
        c.alu_op    = ALUOP_ADD;
      end
      ST_DECODE: begin
        c.alu_src_b = SRCB_BOFF;
        c.alu_op    = ALUOP_ADD;
      end
      ST_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALUOP_RTYPE;
      end
      ST_WB_R: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      ST_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ITYPE;
      end
      ST_WB_I: c.reg_write = 1'b1;
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      ST_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REGB;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      default: c.fault = 1'b1;
    endcase
    return c;
  endfunction

  function automatic state_t decode_next(input logic [3:0] op);
    state_t n;
    case (op)
      OP_R0, OP_R1:               n = ST_EXEC_R;
      OP_I0, OP_I1, OP_I2, OP_I3: n = ST_EXEC_I;
      OP_LW, OP_SW:               n = ST_MEM_ADDR;
      OP_BEQ:                     n = ST_BRANCH;
      default:                    n = ST_FAULT;
    endcase
    return n;
  endfunction

  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating count of cycles spent waiting on MemReady; expired marks the last
// cycle a memory access may still complete before the FSM gives up.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [3:0] LAST = 4'(WAIT_MAX - 1);

  logic [3:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != 4'hF)) begin
      count <= count + 4'd1;
    end
  end

  assign expired = (count >= LAST);

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle control FSM for the cpu16 datapath: sequences fetch, decode,
// execute, memory and write-back, with a timeout on stalled memory accesses.
module main_control_fsm
  import cpu16_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Instr,
  input  logic        MemReady,
  input  logic        Zero,
  output logic [3:0]  Opcode,
  output logic [1:0]  Funct,
  output logic [1:0]  ALUOp,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        PCSource,
  output logic        Fault
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC+1; wait for MemReady
  // DECODE   | branch target into ALUOut, dispatch on opcode
  // EXEC_R   | A op B
  // WB_R     | ALUOut -> rd
  // EXEC_I   | A op sign-extended immediate
  // WB_I     | ALUOut -> rt
  // MEM_ADDR | effective address A + imm
  // MEM_RD   | load data read; wait for MemReady
  // MEM_WR   | store data write; wait for MemReady
  // WB_MEM   | MDR -> rt
  // BRANCH   | A - B, PC <= target when Zero
  // FAULT    | bad opcode or memory timeout; held until Reset

  state_t      state;
  state_t      nxt;
  ctrl_t       ctrl;
  logic [15:0] ir;
  logic        load_ir;
  logic        wait_expired;
  logic        timer_clear;
  logic        timer_en;
  logic        unused_bits;

  always_comb begin
    nxt = state;
    case (state)
      ST_FETCH: begin
        if (MemReady)          nxt = ST_DECODE;
        else if (wait_expired) nxt = ST_FAULT;
      end
      ST_DECODE:   nxt = decode_next(ir[15:12]);
      ST_EXEC_R:   nxt = ST_WB_R;
      ST_WB_R:     nxt = ST_FETCH;
      ST_EXEC_I:   nxt = ST_WB_I;
      ST_WB_I:     nxt = ST_FETCH;
      ST_MEM_ADDR: nxt = (ir[15:12] == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (MemReady)          nxt = ST_WB_MEM;
        else if (wait_expired) nxt = ST_FAULT;
      end
      ST_MEM_WR: begin
        if (MemReady)          nxt = ST_FETCH;
        else if (wait_expired) nxt = ST_FAULT;
      end
      ST_WB_MEM:   nxt = ST_FETCH;
      ST_BRANCH:   nxt = ST_FETCH;
      ST_FAULT:    nxt = ST_FAULT;
      default:     nxt = ST_FAULT;
    endcase
  end

  // Outputs are registered from the next state so they stay pure Moore decodes.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_FETCH;
      ctrl  <= ctrl_decode(ST_FETCH);
    end else begin
      state <= nxt;
      ctrl  <= ctrl_decode(nxt);
    end
  end

  // Reset gating keeps IRWrite/PCWrite low even though reset parks us in FETCH.
  assign load_ir = (state == ST_FETCH) && ctrl.mem_read && MemReady && !Reset;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ir <= '0;
    end else if (load_ir) begin
      ir <= Instr;
    end
  end

  assign timer_clear = (nxt != state);
  assign timer_en    = is_wait_state(state) && !MemReady;

  mem_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(wait_expired)
  );

  // Zero gates the PC write in the datapath; the FSM never needs it.
  assign unused_bits = ^{Zero, ir[11:2]};

  assign Opcode      = ir[15:12];
  assign Funct       = ir[1:0];
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign IRWrite     = load_ir;
  assign PCWrite     = load_ir;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign PCSource    = ctrl.pc_source;
  assign Fault       = ctrl.fault;

endmodule
